// File: rtl/ddr4_refresh_scheduler.sv
// ddr4_refresh_scheduler
// Credit-based DDR4 refresh engine. One credit is earned every TREFI cycles.
// Credits are postponed while the controller is busy, up to MAX_POSTPONE.
// Once the command bus is granted, the engine closes open banks (PREA),
// waits tRP, issues REF and waits tRFC before it hands the bus back.
`timescale 1ns/1ps

module ddr4_refresh_scheduler #(
    parameter int BANKS        = 8,
    parameter int TREFI        = 7800,
    parameter int TRFC         = 350,
    parameter int TRP          = 15,
    parameter int MAX_POSTPONE = 8,
    localparam int OW          = $clog2(MAX_POSTPONE + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             busy_in,
    input  logic [BANKS-1:0] open_banks_in,
    input  logic             grant_in,
    output logic             req_out,
    output logic             cmd_valid_out,
    output logic [1:0]       cmd_out,
    output logic             refresh_active_out,
    output logic             urgent_out,
    output logic [OW-1:0]    owed_out,
    output logic             overflow_out
);

    // Interval counter width and shared wait-counter width.
    localparam int CW       = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam int WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int WW       = $clog2(WAIT_MAX + 1);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PREA = 2'b01;
    localparam logic [1:0] CMD_REF  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_PRE       = 3'd2,
        ST_TRP_WAIT  = 3'd3,
        ST_REF       = 3'd4,
        ST_TRFC_WAIT = 3'd5
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [WW-1:0]   wait_reg;
    logic [WW-1:0]   wait_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [OW-1:0]   owed_reg;
    logic [OW-1:0]   owed_next;
    logic            ovf_reg;
    logic            ovf_next;

    logic            tick;
    logic            done_pulse;
    logic            saturated;
    logic            any_open;

    // OR-reduce the open-bank mask as a simple chain; only consulted in the
    // REQ cycle where the grant is accepted.
    logic [BANKS:0]  open_chain;

    assign open_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_open_chain
            assign open_chain[gi+1] = open_chain[gi] | open_banks_in[gi];
        end
    endgenerate

    assign any_open = open_chain[BANKS];

    // A tick is the last cycle of each refresh interval.
    assign tick       = (cnt_reg == CW'(TREFI - 1));
    // Completion is the final cycle of the tRFC wait.
    assign done_pulse = (state_reg == ST_TRFC_WAIT) && (wait_reg <= WW'(1));
    assign saturated  = (owed_reg == OW'(MAX_POSTPONE));

    // Interval counter wraps at TREFI-1.
    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (tick) begin
            cnt_next = '0;
        end
    end

    // Credit bookkeeping: a tick coinciding with a completion cancels out
    // before saturation is even considered, so overflow cannot fire then.
    always_comb begin
        owed_next = owed_reg;
        ovf_next  = ovf_reg;
        if (tick && done_pulse) begin
            owed_next = owed_reg;
        end else if (tick) begin
            if (saturated) begin
                ovf_next = 1'b1;
            end else begin
                owed_next = owed_reg + OW'(1);
            end
        end else if (done_pulse && (owed_reg != '0)) begin
            owed_next = owed_reg - OW'(1);
        end
    end

    // Interval counter and credit registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_reg  <= '0;
            owed_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            owed_reg <= owed_next;
            ovf_reg  <= ovf_next;
        end
    end

    // FSM state register together with the wait counter it owns.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Next-state logic; wait counters load on entry and count down to 1.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        unique case (state_reg)
            ST_IDLE: begin
                // Urgency overrides a busy controller.
                if ((owed_reg != '0) && (!busy_in || saturated)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once requested, only a grant moves us on; busy is ignored.
                if (grant_in) begin
                    state_next = any_open ? ST_PRE : ST_REF;
                end
            end
            ST_PRE: begin
                state_next = ST_TRP_WAIT;
                wait_next  = WW'(TRP);
            end
            ST_TRP_WAIT: begin
                if (wait_reg <= WW'(1)) begin
                    state_next = ST_REF;
                end else begin
                    wait_next = wait_reg - WW'(1);
                end
            end
            ST_REF: begin
                state_next = ST_TRFC_WAIT;
                wait_next  = WW'(TRFC);
            end
            ST_TRFC_WAIT: begin
                if (wait_reg <= WW'(1)) begin
                    state_next = ST_IDLE;
                end else begin
                    wait_next = wait_reg - WW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so they never depend on inputs
    // within the same cycle.
    always_comb begin
        req_out            = (state_reg == ST_REQ);
        cmd_valid_out      = (state_reg == ST_PRE) || (state_reg == ST_REF);
        cmd_out            = CMD_NOP;
        if (state_reg == ST_PRE) begin
            cmd_out = CMD_PREA;
        end else if (state_reg == ST_REF) begin
            cmd_out = CMD_REF;
        end
        refresh_active_out = (state_reg == ST_PRE)      ||
                             (state_reg == ST_TRP_WAIT) ||
                             (state_reg == ST_REF)      ||
                             (state_reg == ST_TRFC_WAIT);
        urgent_out         = saturated;
        owed_out           = owed_reg;
        overflow_out       = ovf_reg;
    end

endmodule

// File: tb/tb_ddr4_refresh_scheduler.sv
// Testbench for ddr4_refresh_scheduler: a reference model predicts the refresh
// schedule at transaction level (credits and absolute command cycles) and a
// separate monitor compares the DUT against the predictions.
`timescale 1ns/1ps

module tb_ddr4_refresh_scheduler;

    localparam int BANKS = 8;
    localparam int TREFI = 20;
    localparam int TRFC  = 5;
    localparam int TRP   = 3;
    localparam int MAXP  = 4;
    localparam int OW    = $clog2(MAXP + 1);

    logic             clk_in;
    logic             rst_in;
    logic             busy_in;
    logic [BANKS-1:0] open_banks_in;
    logic             grant_in;
    logic             req_out;
    logic             cmd_valid_out;
    logic [1:0]       cmd_out;
    logic             refresh_active_out;
    logic             urgent_out;
    logic [OW-1:0]    owed_out;
    logic             overflow_out;

    ddr4_refresh_scheduler #(
        .BANKS        (BANKS),
        .TREFI        (TREFI),
        .TRFC         (TRFC),
        .TRP          (TRP),
        .MAX_POSTPONE (MAXP)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .busy_in            (busy_in),
        .open_banks_in      (open_banks_in),
        .grant_in           (grant_in),
        .req_out            (req_out),
        .cmd_valid_out      (cmd_valid_out),
        .cmd_out            (cmd_out),
        .refresh_active_out (refresh_active_out),
        .urgent_out         (urgent_out),
        .owed_out           (owed_out),
        .overflow_out       (overflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int cmd;
    } cmd_t;

    typedef struct {
        int cyc;
        int owed;
        int ovf;
        int req;
        int act;
    } stat_t;

    cmd_t  cmd_q[$];
    stat_t stat_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_coincide = 0;

    function automatic void check(string name, int cyc, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    // Reference model: credits per interval plus an arithmetic schedule of
    // the commands that follow each accepted grant.
    initial begin : model
        int  mk;
        int  owed;
        int  ovf;
        int  mode;   // 0 idle, 1 requesting, 2 owns the bus
        int  done;   // cycle in which the bus is handed back
        bit  valid;
        bit  tick;
        bit  dec;
        stat_t s;
        cmd_t  c;
        mk = 0; owed = 0; ovf = 0; mode = 0; done = 0; valid = 0;
        forever begin
            @(negedge clk_in);
            if (valid) begin
                s.cyc  = mk;
                s.owed = owed;
                s.ovf  = ovf;
                s.req  = (mode == 1) ? 1 : 0;
                s.act  = (mode == 2) ? 1 : 0;
                stat_q.push_back(s);
            end
            if (rst_in) begin
                // Commands scheduled beyond this cycle never happen.
                while (cmd_q.size() > 0 && cmd_q[cmd_q.size()-1].cyc > mk)
                    void'(cmd_q.pop_back());
                valid = 1; mk = 0; owed = 0; ovf = 0; mode = 0; done = 0;
            end else if (valid) begin
                tick = ((mk % TREFI) == TREFI - 1);
                dec  = (mode == 2) && (mk == done - 1);
                case (mode)
                    0: if (owed > 0 && (!busy_in || owed == MAXP)) mode = 1;
                    1: if (grant_in) begin
                        if (open_banks_in != '0) begin
                            c.cyc = mk + 1;       c.cmd = 1; cmd_q.push_back(c);
                            c.cyc = mk + 2 + TRP; c.cmd = 2; cmd_q.push_back(c);
                            done  = mk + 3 + TRP + TRFC;
                        end else begin
                            c.cyc = mk + 1;       c.cmd = 2; cmd_q.push_back(c);
                            done  = mk + 2 + TRFC;
                        end
                        mode = 2;
                    end
                    default: if (mk + 1 == done) mode = 0;
                endcase
                if (tick && dec) n_coincide++;
                else if (tick) begin
                    if (owed == MAXP) ovf = 1;
                    else owed++;
                end else if (dec) owed--;
                mk++;
            end
        end
    end

    // Monitor: compares registered outputs for each cycle and consumes the
    // expected command whenever the DUT presents one.
    initial begin : monitor
        stat_t s;
        cmd_t  e;
        forever begin
            @(negedge clk_in);
            #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("owed",     s.cyc, int'(owed_out),     s.owed);
                check("urgent",   s.cyc, int'(urgent_out),   (s.owed == MAXP) ? 1 : 0);
                check("overflow", s.cyc, int'(overflow_out), s.ovf);
                check("req",      s.cyc, int'(req_out),      s.req);
                check("active",   s.cyc, int'(refresh_active_out), s.act);
                if (cmd_valid_out) begin
                    $display("cmd cyc=%0d code=%0d owed=%0d", s.cyc, cmd_out, owed_out);
                    if (cmd_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_cmd cyc=%0d actual=%0d expected=none", s.cyc, cmd_out);
                    end else begin
                        e = cmd_q.pop_front();
                        check("cmd_cycle", s.cyc, s.cyc, e.cyc);
                        check("cmd_code",  s.cyc, int'(cmd_out), e.cmd);
                    end
                end else begin
                    check("nop_code", s.cyc, int'(cmd_out), 0);
                    if (cmd_q.size() > 0 && cmd_q[0].cyc <= s.cyc) begin
                        e = cmd_q.pop_front();
                        n_cmp++; n_err++;
                        $display("FAIL missing_cmd cyc=%0d actual=none expected=%0d@%0d", s.cyc, e.cmd, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // One-cycle reset pulse; returns at the start of the new cycle 0.
    task automatic do_reset();
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
    endtask

    initial begin : stimulus
        rst_in        = 1'b1;
        busy_in       = 1'b0;
        grant_in      = 1'b1;
        open_banks_in = '0;
        step(3);
        rst_in = 1'b0;

        // Idle refresh with no open banks.
        step(60);
        // Open banks at grant time.
        open_banks_in = 8'h05;
        step(60);
        open_banks_in = '0;

        // Postponement while busy, then drain.
        do_reset();
        busy_in = 1'b1;
        step(80);
        busy_in = 1'b0;
        step(120);

        // Overflow with the bus withheld; sticky after grants resume.
        do_reset();
        busy_in  = 1'b1;
        grant_in = 1'b0;
        step(120);
        busy_in  = 1'b0;
        grant_in = 1'b1;
        step(200);

        // Completion aligned with a tick: grant at cycle 33 puts the last
        // tRFC cycle on cycle 39, the second tick.
        do_reset();
        grant_in = 1'b0;
        step(33);
        grant_in = 1'b1;
        step(1);
        grant_in = 1'b0;
        step(20);
        grant_in = 1'b1;
        step(40);

        // Reset in TRP_WAIT (PRE at cycle 22, wait cycles 23..25).
        do_reset();
        open_banks_in = 8'h05;
        step(24);
        do_reset();
        open_banks_in = '0;
        step(60);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            busy_in       = ($urandom_range(0, 3) != 0);
            grant_in      = ($urandom_range(0, 9) < 6);
            open_banks_in = ($urandom_range(0, 1) != 0) ? BANKS'($urandom) : '0;
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(1);
        end

        // Drain outstanding credits.
        busy_in       = 1'b0;
        grant_in      = 1'b1;
        open_banks_in = '0;
        step(100);
        step(2);
        $display("tick/completion coincidences seen: %0d", n_coincide);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
